// File: rtl/user_proj_multicount.sv
// ============================================================================
// Module  : user_proj_multicount
// Purpose : CHANNELS x WIDTH-bit Wishbone up/down counters with limit match,
//           IRQ mask and LA override of channel 0. Optional MULTICOUNT_PRESCALE_EN
//           adds a shared tick prescaler at BASE_ADR+0x104.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif
`timescale 1ns/1ps
`default_nettype none

module user_proj_multicount #(
  parameter int          WIDTH    = 16,
  parameter int          CHANNELS = 2,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          IO_BITS  = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [63:0]              la_data_in,
  output logic [63:0]              la_data_out,
  input  logic [63:0]              la_oenb,
  input  logic [`MPRJ_IO_PADS-1:0] io_in,
  output logic [`MPRJ_IO_PADS-1:0] io_out,
  output logic [`MPRJ_IO_PADS-1:0] io_oeb,
  output logic [2:0]               irq,
  input  logic                     user_clock2
);

  localparam int              PADS        = `MPRJ_IO_PADS;
  localparam logic [31:0]     C_CHANNELS  = 32'(CHANNELS);
  localparam logic [PADS-1:0] C_OEB_VALUE = ~((PADS'(1) << IO_BITS) - PADS'(1));

  logic [31:0] w_off;
  logic        w_req;
  logic        w_wr;
  logic        w_ch_region;
  logic        w_irqmask_hit;
  logic        w_tick;
  logic [31:0] w_bmask;
  logic [31:0] w_rdata;

  logic        ack_q;
  logic [31:0] dat_q;
  logic [63:0] la_q;
  logic [PADS-1:0] io_q;
  logic [2:0]  irq_q;
  logic [CHANNELS-1:0] irqmask_q, irqmask_d;

  logic [WIDTH-1:0]    w_count [CHANNELS];
  logic [WIDTH-1:0]    w_limit [CHANNELS];
  logic [CHANNELS-1:0] w_en, w_dir, w_os, w_match;

  // A request is blocked during its own ack cycle, which forces an idle
  // cycle between consecutive acks.
  assign w_off         = wbs_adr_i - BASE_ADR;
  assign w_req         = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign w_wr          = w_req & wbs_we_i;
  assign w_ch_region   = (w_off[31:8] == 24'd0) && ({28'd0, w_off[7:4]} < C_CHANNELS);
  assign w_irqmask_hit = (w_off[31:2] == 30'h40);
  assign w_bmask       = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                          {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

`ifdef MULTICOUNT_PRESCALE_EN
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       w_prescale_hit;

  assign w_prescale_hit = (w_off[31:2] == 30'h41);
  assign w_tick         = (pcnt_q == prescale_q);

  always_comb begin
    prescale_d = prescale_q;
    pcnt_d     = w_tick ? 8'd0 : pcnt_q + 8'd1;
    if (w_wr && w_prescale_hit) begin
      pcnt_d = 8'd0;
      if (wbs_sel_i[0]) prescale_d = wbs_dat_i[7:0];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      prescale_q <= 8'd0;
      pcnt_q     <= 8'd0;
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] count_q, count_d, limit_q, limit_d;
    logic             en_q, en_d, dir_q, dir_d, os_q, os_d, match_q, match_d;
    logic             match_set;
    logic             hit, wr_ctrl, wr_count, wr_limit, wr_status, ovr;

    assign hit       = w_ch_region && (w_off[7:4] == 4'(i));
    assign wr_ctrl   = w_wr && hit && (w_off[3:2] == 2'd0);
    assign wr_count  = w_wr && hit && (w_off[3:2] == 2'd1);
    assign wr_limit  = w_wr && hit && (w_off[3:2] == 2'd2);
    assign wr_status = w_wr && hit && (w_off[3:2] == 2'd3);
    assign ovr       = (i == 0) && !la_oenb[63];

    // Priority, lowest to highest: counting, Wishbone write, LA override.
    always_comb begin
      en_d      = en_q;
      dir_d     = dir_q;
      os_d      = os_q;
      count_d   = count_q;
      limit_d   = limit_q;
      match_set = 1'b0;

      if (w_tick && en_q && !ovr) begin
        if (!dir_q) begin
          if (count_q == limit_q) begin
            match_set = 1'b1;
            if (os_q) en_d = 1'b0;
            else      count_d = '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            match_set = 1'b1;
            if (os_q) en_d = 1'b0;
            else      count_d = limit_q;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end

      if (wr_ctrl && wbs_sel_i[0]) begin
        en_d  = wbs_dat_i[0];
        dir_d = wbs_dat_i[1];
        os_d  = wbs_dat_i[2];
      end
      if (wr_count)
        count_d = WIDTH'((32'(count_q) & ~w_bmask) | (wbs_dat_i & w_bmask));
      if (wr_limit)
        limit_d = WIDTH'((32'(limit_q) & ~w_bmask) | (wbs_dat_i & w_bmask));

      match_d = match_set | (match_q & ~(wr_status & wbs_sel_i[0] & wbs_dat_i[0]));

      if (ovr) count_d = la_data_in[WIDTH-1:0];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        count_q <= '0;
        limit_q <= '0;
        en_q    <= 1'b0;
        dir_q   <= 1'b0;
        os_q    <= 1'b0;
        match_q <= 1'b0;
      end else begin
        count_q <= count_d;
        limit_q <= limit_d;
        en_q    <= en_d;
        dir_q   <= dir_d;
        os_q    <= os_d;
        match_q <= match_d;
      end
    end

    assign w_count[i] = count_q;
    assign w_limit[i] = limit_q;
    assign w_en[i]    = en_q;
    assign w_dir[i]   = dir_q;
    assign w_os[i]    = os_q;
    assign w_match[i] = match_q;
  end

  always_comb begin
    w_rdata = 32'd0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_ch_region && (w_off[7:4] == 4'(k))) begin
        case (w_off[3:2])
          2'd0:    w_rdata = {29'd0, w_os[k], w_dir[k], w_en[k]};
          2'd1:    w_rdata = 32'(w_count[k]);
          2'd2:    w_rdata = 32'(w_limit[k]);
          default: w_rdata = {31'd0, w_match[k]};
        endcase
      end
    end
    if (w_irqmask_hit) w_rdata = 32'(irqmask_q);
`ifdef MULTICOUNT_PRESCALE_EN
    if (w_prescale_hit) w_rdata = {24'd0, prescale_q};
`endif
  end

  always_comb begin
    irqmask_d = irqmask_q;
    if (w_wr && w_irqmask_hit && wbs_sel_i[0]) irqmask_d = wbs_dat_i[CHANNELS-1:0];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= 32'd0;
      la_q      <= 64'd0;
      io_q      <= '0;
      irq_q     <= 3'd0;
      irqmask_q <= '0;
    end else begin
      ack_q     <= w_req;
      dat_q     <= (w_req && !wbs_we_i) ? w_rdata : 32'd0;
      la_q      <= {w_en[0], w_match[0], 62'(w_count[0])};
      io_q      <= PADS'(w_count[0][IO_BITS-1:0]);
      irq_q     <= {2'b00, |(w_match & irqmask_q)};
      irqmask_q <= irqmask_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign la_data_out = la_q;
  assign io_out      = io_q;
  assign irq         = irq_q;
  // Pad direction never changes, so it is tied to its reset value.
  assign io_oeb      = C_OEB_VALUE;

  logic w_unused;
  assign w_unused = ^{io_in, user_clock2, la_data_in, la_oenb, w_off[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_user_proj_multicount.sv
// ============================================================================
// Module  : tb_user_proj_multicount
// Purpose : Table vectors, corner sequences and random traffic against a
//           cycle-level reference model of user_proj_multicount.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif
`timescale 1ns/1ps
`default_nettype none

module tb_user_proj_multicount;

  localparam int          WIDTH    = 16;
  localparam int          CHANNELS = 2;
  localparam int          IO_BITS  = 16;
  localparam int          PADS     = `MPRJ_IO_PADS;
  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam longint      MOD      = longint'(1) << WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic            stb, cyc, we;
  logic [3:0]      sel;
  logic [31:0]     dat_i, adr;
  logic            ack;
  logic [31:0]     dat_o;
  logic [63:0]     la_in, la_out, la_oenb;
  logic [PADS-1:0] io_in, io_out, io_oeb;
  logic [2:0]      irq;
  logic            uclk2;

  user_proj_multicount #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .BASE_ADR(BASE), .IO_BITS(IO_BITS)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .la_data_in(la_in), .la_data_out(la_out), .la_oenb(la_oenb),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .irq(irq), .user_clock2(uclk2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit [WIDTH-1:0]    m_count [CHANNELS];
  bit [WIDTH-1:0]    m_limit [CHANNELS];
  bit                m_en    [CHANNELS];
  bit                m_dir   [CHANNELS];
  bit                m_os    [CHANNELS];
  bit                m_match [CHANNELS];
  bit [CHANNELS-1:0] m_irqmask;
  bit                m_ack;
  bit [31:0]         m_dat;
  bit [63:0]         m_la;
  bit [PADS-1:0]     m_io;
  bit [2:0]          m_irq;
  int                m_prescale, m_pcnt;

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_count[c] = 0; m_limit[c] = 0; m_en[c] = 0;
      m_dir[c] = 0; m_os[c] = 0; m_match[c] = 0;
    end
    m_irqmask = 0; m_ack = 0; m_dat = 0; m_la = 0; m_io = 0; m_irq = 0;
    m_prescale = 0; m_pcnt = 0;
  endtask

  function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] d, bit [3:0] s);
    bit [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    return v;
  endfunction

  function automatic bit [31:0] mread(bit [31:0] a);
    bit [31:0] off;
    int ch, r;
    off = a - BASE;
    ch  = int'(off / 16);
    r   = int'((off % 16) / 4);
    mread = 0;
    if (off < 256) begin
      if (ch < CHANNELS) begin
        case (r)
          0:       mread = {29'd0, m_os[ch], m_dir[ch], m_en[ch]};
          1:       mread = 32'(m_count[ch]);
          2:       mread = 32'(m_limit[ch]);
          default: mread = {31'd0, m_match[ch]};
        endcase
      end
    end else if (off / 4 == 64) begin
      mread = 32'(m_irqmask);
    end
`ifdef MULTICOUNT_PRESCALE_EN
    else if (off / 4 == 65) mread = 32'(m_prescale);
`endif
  endfunction

  // Advance model and DUT by one clock, then compare every output.
  task automatic step();
    bit [WIDTH-1:0]    n_count [CHANNELS];
    bit [WIDTH-1:0]    n_limit [CHANNELS];
    bit                n_en    [CHANNELS];
    bit                n_dir   [CHANNELS];
    bit                n_os    [CHANNELS];
    bit                n_match [CHANNELS];
    bit [CHANNELS-1:0] n_mask;
    bit                req, tick, set, ovr, w1c, any_irq;
    bit [31:0]         off;
    int                ch, r, n_pcnt, n_ps;
    bit [63:0]         n_la;
    bit [PADS-1:0]     n_io;
    bit [31:0]         n_dat;

    req = stb && cyc && !m_ack;
    n_count = m_count; n_limit = m_limit; n_en = m_en;
    n_dir = m_dir; n_os = m_os; n_match = m_match; n_mask = m_irqmask;
    tick = 1; n_pcnt = 0; n_ps = m_prescale;
`ifdef MULTICOUNT_PRESCALE_EN
    tick   = (m_pcnt == m_prescale);
    n_pcnt = tick ? 0 : m_pcnt + 1;
`endif
    off = adr - BASE;
    ch  = int'(off / 16);
    r   = int'((off % 16) / 4);

    for (int c = 0; c < CHANNELS; c++) begin
      ovr = (c == 0) && !la_oenb[63];
      set = 0;
      if (tick && m_en[c] && !ovr) begin
        if (!m_dir[c]) begin
          if (m_count[c] == m_limit[c]) begin
            set = 1;
            if (m_os[c]) n_en[c] = 0; else n_count[c] = 0;
          end else n_count[c] = WIDTH'((longint'(m_count[c]) + 1) % MOD);
        end else begin
          if (m_count[c] == 0) begin
            set = 1;
            if (m_os[c]) n_en[c] = 0; else n_count[c] = m_limit[c];
          end else n_count[c] = WIDTH'((longint'(m_count[c]) + MOD - 1) % MOD);
        end
      end
      w1c = 0;
      if (req && we && off < 256 && ch == c) begin
        case (r)
          0: if (sel[0]) begin n_en[c] = dat_i[0]; n_dir[c] = dat_i[1]; n_os[c] = dat_i[2]; end
          1: n_count[c] = WIDTH'(merge(32'(m_count[c]), dat_i, sel));
          2: n_limit[c] = WIDTH'(merge(32'(m_limit[c]), dat_i, sel));
          default: w1c = sel[0] && dat_i[0];
        endcase
      end
      n_match[c] = set || (m_match[c] && !w1c);
      if (ovr) n_count[c] = la_in[WIDTH-1:0];
    end
    if (req && we && off / 4 == 64 && sel[0]) n_mask = dat_i[CHANNELS-1:0];
`ifdef MULTICOUNT_PRESCALE_EN
    if (req && we && off / 4 == 65) begin
      n_pcnt = 0;
      if (sel[0]) n_ps = int'(dat_i[7:0]);
    end
`endif

    n_la = 64'(m_count[0]);
    n_la[63] = m_en[0];
    n_la[62] = m_match[0];
    n_io = '0;
    n_io[IO_BITS-1:0] = m_count[0][IO_BITS-1:0];
    any_irq = 0;
    for (int c = 0; c < CHANNELS; c++) any_irq |= m_match[c] && m_irqmask[c];
    n_dat = (req && !we) ? mread(adr) : 32'd0;

    @(posedge clk);
    m_count = n_count; m_limit = n_limit; m_en = n_en;
    m_dir = n_dir; m_os = n_os; m_match = n_match; m_irqmask = n_mask;
    m_pcnt = n_pcnt; m_prescale = n_ps;
    m_ack = req; m_dat = n_dat; m_la = n_la; m_io = n_io; m_irq = {2'b00, any_irq};
    #1;
    chk("ack", ack, m_ack);
    chk("dat_o", dat_o, m_dat);
    chk("la_data_out", la_out, m_la);
    chk("io_out", io_out, m_io);
    chk("irq", irq, m_irq);
  endtask

  task automatic wb(input bit [31:0] a, input bit w, input bit [31:0] d,
                    input bit [3:0] s, input bit hold, output bit [31:0] rd);
    int n;
    adr = BASE + a; we = w; dat_i = d; sel = s; stb = 1; cyc = 1;
    n = 0;
    do begin step(); n++; end while (!m_ack && n < 8);
    rd = dat_o;
    if (hold) step();
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic wr(input bit [31:0] a, input bit [31:0] d);
    bit [31:0] unused_rd;
    wb(a, 1, d, 4'hF, 0, unused_rd);
  endtask

  task automatic rd(input bit [31:0] a, output bit [31:0] v);
    wb(a, 0, 0, 4'hF, 0, v);
  endtask

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit [31:0] v;
    int        found;
    bit [WIDTH-1:0] c0;

    rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
    la_in = 0; la_oenb = '1; io_in = 0; uclk2 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;

    chk("reset_la", la_out, 64'd0);
    chk("reset_io_out", io_out, 0);
    chk("reset_io_oeb", io_oeb, {22'h3FFFFF, 16'h0000});
    chk("reset_irq", irq, 0);
    chk("reset_ack", ack, 0);

    // ack is dropped at once by a reset arriving mid-transaction
    adr = BASE + 32'h4; we = 0; stb = 1; cyc = 1;
    step();
    rst = 1;
    #1;
    chk("midreset_ack", ack, 0);
    chk("midreset_dat", dat_o, 0);
    stb = 0; cyc = 0;
    model_reset();
    #2 rst = 0;

    tbl.push_back('{32'h000, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h004, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h008, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h00C, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h010, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h014, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h018, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h01C, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h100, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h104, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h008, 1, 32'hFFFF_ABCD, 4'hF, 32'h0});
    tbl.push_back('{32'h008, 0, 0, 4'hF, 32'h0000_ABCD});
    tbl.push_back('{32'h008, 1, 32'h0000_1200, 4'h2, 32'h0});
    tbl.push_back('{32'h008, 0, 0, 4'hF, 32'h0000_12CD});
    tbl.push_back('{32'h020, 1, 32'hFFFF_FFFF, 4'hF, 32'h0});
    tbl.push_back('{32'h020, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h028, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h008, 0, 0, 4'hF, 32'h0000_12CD});
    tbl.push_back('{32'h018, 1, 32'hAA55_5555, 4'h1, 32'h0});
    tbl.push_back('{32'h018, 0, 0, 4'hF, 32'h0000_0055});
    tbl.push_back('{32'h100, 1, 32'h0000_00FF, 4'hF, 32'h0});
    tbl.push_back('{32'h100, 0, 0, 4'hF, 32'h0000_0003});
    tbl.push_back('{32'h100, 1, 32'h0000_0000, 4'hE, 32'h0});
    tbl.push_back('{32'h100, 0, 0, 4'hF, 32'h0000_0003});
    tbl.push_back('{32'h100, 1, 32'h0000_0000, 4'hF, 32'h0});
    tbl.push_back('{32'h100, 0, 0, 4'hF, 32'h0});
    tbl.push_back('{32'h300, 1, 32'h1234_5678, 4'hF, 32'h0});
    tbl.push_back('{32'h300, 0, 0, 4'hF, 32'h0});
    foreach (tbl[i]) begin
      wb(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].s, 0, v);
      if (!tbl[i].w) chk($sformatf("tbl%0d_read_0x%0h", i, tbl[i].a), v, tbl[i].exp);
    end

    // channel 0: up count with reload at LIMIT=5
    wr(32'h008, 5);
    wr(32'h000, 1);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (la_out[15:0] == 16'd5) found = 1;
    end
    chk("ch0_reach_limit", found, 1);
    step();
    chk("ch0_wrap_count", la_out[15:0], 0);
    chk("ch0_match_flag", la_out[62], 1);
    chk("ch0_irq_masked", irq, 0);
    wr(32'h100, 1);
    step(); step();
    chk("ch0_irq_unmasked", irq, 1);
    wr(32'h000, 0);
    wr(32'h00C, 1);
    step(); step();
    chk("ch0_irq_w1c", irq, 0);

    // channel 1: oneshot down count from 3
    wr(32'h014, 3);
    wr(32'h010, 7);
    repeat (8) step();
    rd(32'h010, v);
    chk("ch1_en_cleared", v & 32'h1, 0);
    rd(32'h014, v);
    chk("ch1_hold_zero", v, 0);
    rd(32'h01C, v);
    chk("ch1_match", v, 1);

    // LA override beats counting and a concurrent COUNT write
    wr(32'h000, 1);
    la_in = 64'h1234;
    la_oenb[63] = 0;
    wr(32'h004, 32'h55);
    step();
    chk("la_ovr_la_out", la_out[15:0], 16'h1234);
    chk("la_ovr_io_out", io_out[15:0], 16'h1234);
    rd(32'h004, v);
    chk("la_ovr_count", v, 32'h1234);
    la_oenb = '1;
    wr(32'h000, 0);

`ifdef MULTICOUNT_PRESCALE_EN
    wr(32'h104, 3);
    wr(32'h008, 32'hFFFF);
    wr(32'h004, 0);
    wr(32'h000, 1);
    step();
    c0 = la_out[WIDTH-1:0];
    repeat (8) step();
    chk("prescale_rate", la_out[WIDTH-1:0] - c0, 2);
    wr(32'h000, 0);
`else
    c0 = 0;
`endif

    for (int t = 0; t < 400; t++) begin
      bit [31:0] a, d;
      case ($urandom_range(0, 9))
        0:       a = 32'h100;
        1:       a = 32'h104;
        2:       a = 32'h200 + 4 * $urandom_range(0, 15);
        default: a = 4 * $urandom_range(0, 11);
      endcase
      d = $urandom;
      if ($urandom_range(0, 2) != 0) d = $urandom_range(0, 7);
      la_oenb[63] = ($urandom_range(0, 7) != 0);
      la_in = {$urandom, $urandom};
      wb(a, 1'($urandom_range(0, 1)), d, 4'($urandom_range(0, 15)),
         $urandom_range(0, 3) == 0, v);
      repeat ($urandom_range(0, 3)) step();
    end
    la_oenb = '1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
